// File: rtl/rst_mgmt_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and
// the software-visible cause encodings.
package rst_mgmt_pkg;

  // Cause encodings as software sees them in the CSR map.
  localparam logic [1:0] CSR_CAUSE_POR       = 2'd0;
  localparam logic [1:0] CSR_CAUSE_LOCK_LOSS = 2'd1;
  localparam logic [1:0] CSR_CAUSE_SOFT      = 2'd2;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    REL_PERIPH,
    RUN,
    SOFT_HOLD
  } state_t;

  typedef enum logic [1:0] {
    POR       = CSR_CAUSE_POR,
    LOCK_LOSS = CSR_CAUSE_LOCK_LOSS,
    SOFT      = CSR_CAUSE_SOFT
  } rst_cause_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_mgmt_sync_ff.sv
// N-stage synchronizer with asynchronous clear; output is the last stage,
// so it is low while cleared and follows d after STAGES edges.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_mgmt.sv
// Reset sequencer: qualifies PLL lock, releases peripheral then core reset,
// reasserts on lock loss or software request and records the last cause.
module rst_mgmt
  import rst_mgmt_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int SOFT_RST_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       soft_rst_req_i,
  output logic       rst_periph_n_o,
  output logic       rst_core_n_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);

  localparam int CNT_MAX = max3(LOCK_FILTER_CYCLES, CORE_DELAY_CYCLES, SOFT_RST_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Each phase ends on the edge that completes its Nth qualifying cycle.
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CORE_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_RST_CYCLES - 1);

  logic             rst_sync;
  logic             locked_s;
  logic             lock_lost;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             periph, periph_nxt;
  logic             core, core_nxt;
  logic             done, done_nxt;
  rst_cause_t       cause, cause_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked_i),
    .q     (locked_s)
  );

  assign cnt_inc   = (cnt == CNT_TOP) ? cnt : cnt + CNT_W'(1);
  assign lock_lost = !locked_s && (state == REL_PERIPH || state == RUN || state == SOFT_HOLD);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    periph_nxt = periph;
    core_nxt   = core;
    done_nxt   = done;
    cause_nxt  = cause;
    case (state)
      RESET: begin
        cnt_nxt = '0;
        if (rst_sync) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!locked_s) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt  = REL_PERIPH;
          cnt_nxt    = '0;
          periph_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      REL_PERIPH: begin
        if (cnt == CORE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          core_nxt  = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RUN: begin
        if (soft_rst_req_i) begin
          state_nxt  = SOFT_HOLD;
          cnt_nxt    = '0;
          periph_nxt = 1'b0;
          core_nxt   = 1'b0;
          done_nxt   = 1'b0;
          cause_nxt  = SOFT;
        end
      end
      SOFT_HOLD: begin
        if (cnt == SOFT_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = RESET;
    endcase
    // Lock loss overrides everything above, including a same-cycle soft request.
    if (lock_lost) begin
      state_nxt  = WAIT_LOCK;
      cnt_nxt    = '0;
      periph_nxt = 1'b0;
      core_nxt   = 1'b0;
      done_nxt   = 1'b0;
      cause_nxt  = LOCK_LOSS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RESET;
      cnt    <= '0;
      periph <= 1'b0;
      core   <= 1'b0;
      done   <= 1'b0;
      cause  <= POR;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      periph <= periph_nxt;
      core   <= core_nxt;
      done   <= done_nxt;
      cause  <= cause_nxt;
    end
  end

  assign rst_periph_n_o = periph;
  assign rst_core_n_o   = core;
  assign rst_done_o     = done;
  assign rst_cause_o    = cause;

endmodule

// File: tb/tb_rst_mgmt.sv
// Self-checking bench for rst_mgmt: directed vector table, hand-written
// corner sequences and a randomized run against a phase/timer reference model.
module tb_rst_mgmt;

  localparam int SYNC = 2;
  localparam int LFC  = 8;
  localparam int CDC  = 4;
  localparam int SRC  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       soft_rst_req_i = 1'b0;
  logic       rst_periph_n_o;
  logic       rst_core_n_o;
  logic       rst_done_o;
  logic [1:0] rst_cause_o;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  // Reference model: a phase plus a "cycles still needed" down-timer.
  typedef enum {M_BOOT, M_FILTER, M_DELAY, M_UP, M_HOLD} mphase_t;
  mphase_t    m_phase;
  int         m_left;
  logic       m_periph, m_core, m_done;
  logic [1:0] m_cause;
  logic       samp[$];

  typedef struct {
    logic       lk;
    logic       sr;
    logic       periph;
    logic       core;
    logic       done;
    logic [1:0] cause;
  } vec_t;
  vec_t vecs[20];

  rst_mgmt #(
    .SYNC_STAGES        (SYNC),
    .LOCK_FILTER_CYCLES (LFC),
    .CORE_DELAY_CYCLES  (CDC),
    .SOFT_RST_CYCLES    (SRC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked_i),
    .soft_rst_req_i (soft_rst_req_i),
    .rst_periph_n_o (rst_periph_n_o),
    .rst_core_n_o   (rst_core_n_o),
    .rst_done_o     (rst_done_o),
    .rst_cause_o    (rst_cause_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic lk, input logic sr, input logic p,
                              input logic c, input logic d, input logic [1:0] cause);
    vec_t v;
    v.lk = lk; v.sr = sr; v.periph = p; v.core = c; v.done = d; v.cause = cause;
    return v;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic expectNow(input string tag, input logic p, input logic c,
                           input logic d, input logic [1:0] cause);
    chk({tag, ".periph"}, {1'b0, rst_periph_n_o}, {1'b0, p});
    chk({tag, ".core"},   {1'b0, rst_core_n_o},   {1'b0, c});
    chk({tag, ".done"},   {1'b0, rst_done_o},     {1'b0, d});
    chk({tag, ".cause"},  rst_cause_o,            cause);
  endtask

  task automatic checkOutput(input string tag);
    expectNow(tag, m_periph, m_core, m_done, m_cause);
  endtask

  task automatic modelReset();
    m_phase = M_BOOT; m_left = 0;
    m_periph = 1'b0; m_core = 1'b0; m_done = 1'b0; m_cause = 2'd0;
    samp.delete();
    edge_no = 0;
  endtask

  task automatic modelLoss();
    m_phase = M_FILTER; m_left = LFC;
    m_periph = 1'b0; m_core = 1'b0; m_done = 1'b0; m_cause = 2'd1;
  endtask

  task automatic modelEdge(input logic lk, input logic sr);
    logic ls;
    edge_no++;
    // The FSM sees the lock input as it was sampled SYNC edges earlier.
    ls = (samp.size() >= SYNC) ? samp[samp.size() - SYNC] : 1'b0;
    samp.push_back(lk);
    if (samp.size() > SYNC) void'(samp.pop_front());
    case (m_phase)
      M_BOOT: if (edge_no > SYNC) begin m_phase = M_FILTER; m_left = LFC; end
      M_FILTER: begin
        if (!ls) m_left = LFC;
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = M_DELAY; m_left = CDC; m_periph = 1'b1; end
        end
      end
      M_DELAY: begin
        if (!ls) modelLoss();
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = M_UP; m_core = 1'b1; m_done = 1'b1; end
        end
      end
      M_UP: begin
        if (!ls) modelLoss();
        else if (sr) begin
          m_phase = M_HOLD; m_left = SRC;
          m_periph = 1'b0; m_core = 1'b0; m_done = 1'b0; m_cause = 2'd2;
        end
      end
      M_HOLD: begin
        if (!ls) modelLoss();
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = M_FILTER; m_left = LFC; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic lk, input logic sr);
    pll_locked_i = lk;
    soft_rst_req_i = sr;
    @(posedge clk);
    modelEdge(lk, sr);
    @(negedge clk);
    soft_rst_req_i = 1'b0;
    checkOutput("model");
  endtask

  // Asserts rst_n mid-cycle, checks the asynchronous clear, releases on a falling edge.
  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    soft_rst_req_i = 1'b0;
    #2;
    expectNow("async_reset", 1'b0, 1'b0, 1'b0, 2'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic lk_cur;
    // Power-on with lock held high, then a soft request at edge 17.
    for (int i = 0; i < 10; i++) vecs[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    vecs[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    vecs[15] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);

    @(negedge clk);
    resetDut();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].lk, vecs[i].sr);
      expectNow($sformatf("vec%0d", i + 1), vecs[i].periph, vecs[i].core, vecs[i].done, vecs[i].cause);
    end
    // Soft hold ends at edge 23; release follows the full lock filter.
    for (int e = 21; e <= 35; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (e == 30) expectNow("soft_periph_held", 1'b0, 1'b0, 1'b0, 2'd2);
      if (e == 31) expectNow("soft_periph_rel",  1'b1, 1'b0, 1'b0, 2'd2);
      if (e == 34) expectNow("soft_core_held",   1'b1, 1'b0, 1'b0, 2'd2);
      if (e == 35) expectNow("soft_core_rel",    1'b1, 1'b1, 1'b1, 2'd2);
    end

    $display("[TB] lock glitch during filter, then lock loss in RUN");
    resetDut();
    for (int e = 1; e <= 22; e++) begin
      applyStimulus((e == 7) ? 1'b0 : 1'b1, 1'b0);
      if (e == 11) expectNow("glitch_no_early", 1'b0, 1'b0, 1'b0, 2'd0);
      if (e == 16) expectNow("glitch_periph_held", 1'b0, 1'b0, 1'b0, 2'd0);
      if (e == 17) expectNow("glitch_periph_rel",  1'b1, 1'b0, 1'b0, 2'd0);
      if (e == 20) expectNow("glitch_core_held",   1'b1, 1'b0, 1'b0, 2'd0);
      if (e == 21) expectNow("glitch_core_rel",    1'b1, 1'b1, 1'b1, 2'd0);
    end
    for (int e = 23; e <= 40; e++) begin
      applyStimulus((e >= 23 && e <= 26) ? 1'b0 : 1'b1, 1'b0);
      if (e == 24) expectNow("loss_not_yet",     1'b1, 1'b1, 1'b1, 2'd0);
      if (e == 25) expectNow("loss_asserted",    1'b0, 1'b0, 1'b0, 2'd1);
      if (e == 35) expectNow("relock_held",      1'b0, 1'b0, 1'b0, 2'd1);
      if (e == 36) expectNow("relock_periph",    1'b1, 1'b0, 1'b0, 2'd1);
      if (e == 39) expectNow("relock_core_held", 1'b1, 1'b0, 1'b0, 2'd1);
      if (e == 40) expectNow("relock_core",      1'b1, 1'b1, 1'b1, 2'd1);
    end

    $display("[TB] soft request coinciding with lock loss");
    resetDut();
    for (int e = 1; e <= 33; e++) begin
      applyStimulus((e >= 16 && e <= 19) ? 1'b0 : 1'b1,
                    (e == 18 || e == 19 || e == 23 || e == 31) ? 1'b1 : 1'b0);
      if (e == 15) expectNow("both_run",        1'b1, 1'b1, 1'b1, 2'd0);
      if (e == 18) expectNow("both_loss_wins",  1'b0, 1'b0, 1'b0, 2'd1);
      if (e == 28) expectNow("both_held",       1'b0, 1'b0, 1'b0, 2'd1);
      if (e == 29) expectNow("both_periph_rel", 1'b1, 1'b0, 1'b0, 2'd1);
      if (e == 33) expectNow("both_core_rel",   1'b1, 1'b1, 1'b1, 2'd1);
    end
    // Lose lock again, then hit rst_n while the core is still in reset.
    for (int e = 34; e <= 45; e++) begin
      applyStimulus((e == 34) ? 1'b0 : 1'b1, 1'b0);
      if (e == 44) expectNow("relp_periph", 1'b1, 1'b0, 1'b0, 2'd1);
    end
    resetDut();
    for (int e = 1; e <= 15; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (e == 10) expectNow("restart_held",  1'b0, 1'b0, 1'b0, 2'd0);
      if (e == 11) expectNow("restart_periph", 1'b1, 1'b0, 1'b0, 2'd0);
      if (e == 15) expectNow("restart_core",  1'b1, 1'b1, 1'b1, 2'd0);
    end

    $display("[TB] randomized run");
    resetDut();
    lk_cur = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (lk_cur) lk_cur = ($urandom_range(0, 149) != 0);
      else        lk_cur = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) resetDut();
      applyStimulus(lk_cur, ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
